xb_vc_arbiter: RTL and testbench
================================

# xb_vc_arbiter

Local VC arbiter for one crossbar input port. Each cycle it picks one requesting virtual channel (VC) and drives the one-hot `sel` of the input-port VC multiplexer. It forwards that VC's request to the main switch allocator on behalf of the port. When the main allocator grants the port, it returns a dequeue strobe to the winning VC. One instance sits beside each input-port multiplexer, forming the first stage of the 2-stage switch allocation.

## Interface
Parameters (set from the global defines):
- `V`, 4: VCs per input port; the supported range is 2..8.
- `VW`, $clog2(`V`): width of a VC index.

Ports:
- `clk`  input  1  core clock.
- `rstn`  input  1  asynchronous, active-low reset.
- `vc_req`  input  `V`  bit i = VC i has a flit at its queue head and a downstream credit.
- `vc_tail`  input  `V`  bit i = the head flit of VC i is a tail flit (a single-flit packet counts as head+tail).
- `port_gnt`  input  1  main allocator grant for this port, sampled in the same cycle as `port_req`.
- `sel`  output  `V`  one-hot (or all-zero) select to the input-port multiplexer.
- `port_req`  output  1  request to the main allocator.
- `vc_deq`  output  `V`  one-hot, 1-cycle dequeue strobe to the granted VC.
- `lock_active`  output  1  the port is mid-packet and the selection is locked.

## Operation
- Clock and reset: one clock, `clk`. Reset `rstn` is asynchronous and active-low.
- State:
  - `ptr` (`VW` bits): index of the highest-priority VC.
  - FSM {IDLE, LOCKED}.
  - `lock_vc` (`VW` bits): the VC that owns the lock.
- Reset values:
  - `ptr`=0, state=IDLE, `lock_vc`=0.
  - Outputs after reset: `sel`=0, `port_req`=0, `vc_deq`=0, `lock_active`=0 (all outputs follow from these with `vc_req`=0).
- IDLE behaviour:
  - Winner = first set bit of `vc_req`, scanning from `ptr` upward with wrap-around from `V`-1 to 0.
  - `sel` = one-hot(winner) and `port_req`=1.
  - If `vc_req`=0, then `sel`=0 and `port_req`=0.
- LOCKED behaviour:
  - `sel` = one-hot(`lock_vc`) unconditionally, held even while that VC bubbles.
  - `port_req` = `vc_req[lock_vc]`.
  - Other VCs are never selected, even if they request.
- Grant event: `port_gnt & port_req` in a cycle.
  - `vc_deq` = `sel` in that cycle; otherwise `vc_deq`=0.
  - On the next edge: `ptr` <= (granted index + 1) mod `V`, so the winner drops to lowest priority.
- FSM transitions, all on a grant event:
  - IDLE -> LOCKED when the granted flit is not a tail; `lock_vc` <= granted index.
  - LOCKED -> IDLE when `vc_tail[lock_vc]`=1.
  - IDLE with a tail-flit grant stays in IDLE.
  - LOCKED with a non-tail grant stays in LOCKED.
- Ignored inputs:
  - `port_gnt` is ignored when `port_req`=0: no deq strobe, no state change.
  - `vc_tail[i]` is ignored when `vc_req[i]`=0.
- `lock_active` = (state==LOCKED).
- Mid-operation reset: an assertion asynchronously returns the block to its reset values in the same cycle. Any packet lock is discarded; flushing the VCs is the owner's responsibility.

## Timing
- `sel`, `port_req` and `vc_deq` are combinational from the registered state plus `vc_req` / `vc_tail` / `port_gnt`: zero-cycle arbitration latency.
- `ptr`, the FSM and `lock_vc` update only on the rising `clk` edge following a grant event.
- Back-to-back grants are supported: one flit per cycle per port.
- Only `vc_deq` depends combinationally on `port_gnt`. There is no path from `port_gnt` to `port_req`, which avoids a loop with the main allocator.

## Configuration
- `XB_PKT_LOCK_EN` defined: packet-level (wormhole) locking as described above.
- `XB_PKT_LOCK_EN` undefined:
  - The FSM and `lock_vc` are removed; `lock_active` is tied to 0 and `vc_tail` is unused.
  - Every cycle behaves as IDLE, giving flit-level round-robin.
  - This mode is only legal when the main allocator itself holds outputs per packet.

## Structure
- Shared package: `V`, `DW`, `VW`, and the FSM state encoding (IDLE=1'b0, LOCKED=1'b1).
- One sub-module, `rr_arb`: a combinational round-robin arbiter. Inputs are `req[V]` and `ptr[VW]`; outputs are a one-hot `gnt[V]` and a `gnt_idx[VW]`.
- The top level holds `ptr`, the FSM, the lock muxing and the `vc_deq` generation.

## Test plan
All scenarios use `V`=4.
- Reset: hold `rstn`=0 with `vc_req`=4'b1111 -> `sel`=4'b0001, `port_req`=1. After a grant with tail=1, `ptr`=1, so next cycle `sel`=4'b0010.
- Round robin: `vc_req`=4'b1111, all tails, `port_gnt`=1 for 5 cycles -> `sel` sequence 0001, 0010, 0100, 1000, 0001.
- Wrap: `ptr`=3, `vc_req`=4'b0011 -> `sel`=4'b0001. After the grant, `ptr`=1.
- Lock (`XB_PKT_LOCK_EN`): VC1 sends a 3-flit packet with VC2 also requesting -> `sel`=0010 for all 3 grants and `lock_active`=1 until the tail grant. The next cycle `sel`=0100.
- Bubble while locked: `vc_req[1]` drops mid-packet -> `port_req`=0, `sel` stays 0010, `vc_deq`=0, and VC2 is not selected.
- Reset mid-packet: assert `rstn`=0 while LOCKED -> `lock_active`=0 immediately, and after release `sel` follows `ptr`=0.

Source files
------------

// File: rtl/xb_vc_arbiter_pkg.sv
// Shared VC arbiter types: VC count and index width, flit width, lock FSM encoding.
// No logic; sizes the input-port VC mux and its arbiter.
// V is the VC count per input port (supported range 2..8).
package xb_vc_arbiter_pkg;

  localparam int V  = 4;
  localparam int VW = (V > 1) ? $clog2(V) : 1;
  localparam int DW = 64;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  // Round-robin successor; V need not be a power of two.
  function automatic logic [VW-1:0] next_idx(input logic [VW-1:0] idx);
    return (idx == VW'(V - 1)) ? '0 : idx + VW'(1);
  endfunction

endpackage

// File: rtl/xb_vc_arbiter_if.sv
// VC-side request/grant bundle between one input port's VC queues and its arbiter.
// Latency: none, plain wires.
// Backpressure: port_gnt from the main allocator; VCs wait for their vc_deq strobe.
interface xb_vc_arbiter_if;
  import xb_vc_arbiter_pkg::*;

  logic [V-1:0] vc_req;
  logic [V-1:0] vc_tail;
  logic         port_gnt;
  logic [V-1:0] sel;
  logic         port_req;
  logic [V-1:0] vc_deq;
  logic         lock_active;

  modport master (
    input  vc_req, vc_tail, port_gnt,
    output sel, port_req, vc_deq, lock_active
  );

  modport slave (
    output vc_req, vc_tail, port_gnt,
    input  sel, port_req, vc_deq, lock_active
  );

endinterface

// File: rtl/xb_vc_arbiter_rr_arb.sv
// Combinational round-robin arbiter: the first request at or above ptr wins, wrapping at V-1.
// Latency: zero (pure function of req/ptr).
// Backpressure: none; the caller decides when ptr advances.
module rr_arb
  import xb_vc_arbiter_pkg::*;
(
  input  logic [V-1:0]  req,
  input  logic [VW-1:0] ptr,
  output logic [V-1:0]  gnt,
  output logic [VW-1:0] gnt_idx
);

  logic [VW-1:0] idx;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    idx     = '0;
    // Walk from lowest to highest priority so the best hit is written last.
    for (int k = V - 1; k >= 0; k--) begin
      idx = VW'((int'(ptr) + k) % V);
      if (req[idx]) begin
        gnt      = '0;
        gnt[idx] = 1'b1;
        gnt_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/xb_vc_arbiter.sv
// Local VC arbiter for one input port: picks a VC and requests the main switch allocator for it.
// Latency: zero-cycle select; ptr/lock update on the edge after port_gnt & port_req.
// Backpressure: a VC holds until vc_deq; with XB_PKT_LOCK_EN the packet owner keeps sel through bubbles.
module xb_vc_arbiter
  import xb_vc_arbiter_pkg::*;
(
  input logic             clk,
  input logic             rstn,
  xb_vc_arbiter_if.master bus
);

  logic [VW-1:0] ptr_q;
  logic [V-1:0]  rr_gnt;
  logic [VW-1:0] rr_idx;
  logic [V-1:0]  sel;
  logic [VW-1:0] win_idx;
  logic          port_req;
  logic          gnt_evt;

  rr_arb u_rr_arb (
    .req     (bus.vc_req),
    .ptr     (ptr_q),
    .gnt     (rr_gnt),
    .gnt_idx (rr_idx)
  );

`ifdef XB_PKT_LOCK_EN
  state_e        state_q, state_d;
  logic [VW-1:0] lock_vc_q, lock_vc_d;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      lock_vc_q <= '0;
    end else begin
      state_q   <= state_d;
      lock_vc_q <= lock_vc_d;
    end
  end

  // A locked port keeps its mux pointed at the owner even while it bubbles.
  always_comb begin
    sel      = rr_gnt;
    port_req = |bus.vc_req;
    win_idx  = rr_idx;
    if (state_q == LOCKED) begin
      sel            = '0;
      sel[lock_vc_q] = 1'b1;
      port_req       = bus.vc_req[lock_vc_q];
      win_idx        = lock_vc_q;
    end
  end

  always_comb begin
    state_d   = state_q;
    lock_vc_d = lock_vc_q;
    if (gnt_evt) begin
      case (state_q)
        IDLE: begin
          if (!bus.vc_tail[win_idx]) begin
            state_d   = LOCKED;
            lock_vc_d = win_idx;
          end
        end
        LOCKED: begin
          if (bus.vc_tail[lock_vc_q]) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign bus.lock_active = (state_q == LOCKED);
`else
  logic unused_tail;

  assign sel             = rr_gnt;
  assign port_req        = |bus.vc_req;
  assign win_idx         = rr_idx;
  assign unused_tail     = ^bus.vc_tail;
  assign bus.lock_active = 1'b0;
`endif

  // port_gnt only reaches vc_deq and state, never port_req.
  assign gnt_evt = bus.port_gnt & port_req;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)        ptr_q <= '0;
    else if (gnt_evt) ptr_q <= next_idx(win_idx);
  end

  assign bus.sel      = sel;
  assign bus.port_req = port_req;
  assign bus.vc_deq   = gnt_evt ? sel : '0;

endmodule

// File: tb/tb_xb_vc_arbiter.sv
// Bench for xb_vc_arbiter (V=4): directed scenarios plus a random back-to-back run.
// Expected {sel, port_req, vc_deq, lock_active} is queued at drive time and popped at the negedge.
module tb_xb_vc_arbiter;
  import xb_vc_arbiter_pkg::*;

  typedef logic [9:0] out_t;  // {sel[3:0], port_req, vc_deq[3:0], lock_active}

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  int   checks = 0;
  int   errors = 0;
  out_t  exp_q[$];
  string name_q[$];

  xb_vc_arbiter_if bus ();

  xb_vc_arbiter dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic [V-1:0] req, input logic [V-1:0] tail, input logic gnt,
                       input out_t exp, input string nm);
    bus.vc_req   = req;
    bus.vc_tail  = tail;
    bus.port_gnt = gnt;
    exp_q.push_back(exp);
    name_q.push_back(nm);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn         = 1'b0;
    bus.vc_req   = '0;
    bus.vc_tail  = '0;
    bus.port_gnt = 1'b0;
    #2;
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    logic [V-1:0] req_t [4] = '{4'b0000, 4'b1111, 4'b1111, 4'b1111};
    logic         gnt_t [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    out_t exp_t [4] = '{10'b0000_0_0000_0, 10'b0001_1_0000_0, 10'b0001_1_0001_0, 10'b0010_1_0000_0};
    out_t obs, e;
    string nm;
    for (int i = 0; i < 4; i++) begin
      if (i < 2) begin
        rstn = 1'b0;
        drive(req_t[i], 4'b1111, gnt_t[i], exp_t[i], "reset");
        #2;
      end else begin
        rstn = 1'b1;
        @(posedge clk); #1;
        drive(req_t[i], 4'b1111, gnt_t[i], exp_t[i], "reset_release");
        @(negedge clk);
      end
      obs = {bus.sel, bus.port_req, bus.vc_deq, bus.lock_active};
      e = exp_q.pop_front(); nm = name_q.pop_front(); checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL %s[%0d]: got %b want %b (sel_req_deq_lock)", nm, i, obs, e);
      end
    end
  endtask

  task automatic test_round_robin();
    logic [V-1:0] s;
    out_t obs, e;
    string nm;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      s = 4'b0001 << (i % 4);
      @(posedge clk); #1;
      drive(4'b1111, 4'b1111, 1'b1, {s, 1'b1, s, 1'b0}, "round_robin");
      @(negedge clk);
      obs = {bus.sel, bus.port_req, bus.vc_deq, bus.lock_active};
      e = exp_q.pop_front(); nm = name_q.pop_front(); checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL %s[%0d]: got %b want %b (sel_req_deq_lock)", nm, i, obs, e);
      end
    end
  endtask

  task automatic test_wrap();
    logic [V-1:0] req_t [4] = '{4'b0100, 4'b0011, 4'b0011, 4'b0001};
    logic         gnt_t [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    out_t exp_t [4] = '{10'b0100_1_0100_0, 10'b0001_1_0001_0, 10'b0010_1_0000_0, 10'b0001_1_0000_0};
    out_t obs, e;
    string nm;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      drive(req_t[i], 4'b1111, gnt_t[i], exp_t[i], "wrap");
      @(negedge clk);
      obs = {bus.sel, bus.port_req, bus.vc_deq, bus.lock_active};
      e = exp_q.pop_front(); nm = name_q.pop_front(); checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL %s[%0d]: got %b want %b (sel_req_deq_lock)", nm, i, obs, e);
      end
    end
  endtask

  task automatic test_ignored_gnt();
    logic [V-1:0] req_t [4] = '{4'b0000, 4'b1111, 4'b1111, 4'b1111};
    logic         gnt_t [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    out_t exp_t [4] = '{10'b0000_0_0000_0, 10'b0001_1_0000_0, 10'b0001_1_0001_0, 10'b0010_1_0000_0};
    out_t obs, e;
    string nm;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      drive(req_t[i], 4'b1111, gnt_t[i], exp_t[i], "ignored_gnt");
      @(negedge clk);
      obs = {bus.sel, bus.port_req, bus.vc_deq, bus.lock_active};
      e = exp_q.pop_front(); nm = name_q.pop_front(); checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL %s[%0d]: got %b want %b (sel_req_deq_lock)", nm, i, obs, e);
      end
    end
  endtask

`ifdef XB_PKT_LOCK_EN
  task automatic test_lock();
    logic [V-1:0] tail_t [4] = '{4'b0000, 4'b0000, 4'b0010, 4'b0110};
    logic         gnt_t  [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    out_t exp_t [4] = '{10'b0010_1_0010_0, 10'b0010_1_0010_1, 10'b0010_1_0010_1, 10'b0100_1_0000_0};
    out_t obs, e;
    string nm;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      drive(4'b0110, tail_t[i], gnt_t[i], exp_t[i], "lock");
      @(negedge clk);
      obs = {bus.sel, bus.port_req, bus.vc_deq, bus.lock_active};
      e = exp_q.pop_front(); nm = name_q.pop_front(); checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL %s[%0d]: got %b want %b (sel_req_deq_lock)", nm, i, obs, e);
      end
    end
  endtask

  task automatic test_bubble();
    logic [V-1:0] req_t  [4] = '{4'b0110, 4'b0100, 4'b0110, 4'b0100};
    logic [V-1:0] tail_t [4] = '{4'b0000, 4'b0010, 4'b0010, 4'b0000};
    out_t exp_t [4] = '{10'b0010_1_0010_0, 10'b0010_0_0000_1, 10'b0010_1_0010_1, 10'b0100_1_0000_0};
    logic         gnt_t  [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    out_t obs, e;
    string nm;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      drive(req_t[i], tail_t[i], gnt_t[i], exp_t[i], "bubble");
      @(negedge clk);
      obs = {bus.sel, bus.port_req, bus.vc_deq, bus.lock_active};
      e = exp_q.pop_front(); nm = name_q.pop_front(); checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL %s[%0d]: got %b want %b (sel_req_deq_lock)", nm, i, obs, e);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [V-1:0] req_t  [4] = '{4'b0100, 4'b1111, 4'b1111, 4'b1111};
    logic [V-1:0] tail_t [4] = '{4'b0000, 4'b0000, 4'b0000, 4'b1111};
    logic         gnt_t  [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    out_t exp_t [4] = '{10'b0100_1_0100_0, 10'b0100_1_0000_1, 10'b0001_1_0000_0, 10'b0001_1_0000_0};
    out_t obs, e;
    string nm;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      if (i == 2) begin
        #2;
        rstn = 1'b0;
        drive(req_t[i], tail_t[i], gnt_t[i], exp_t[i], "reset_mid_async");
        #1;
      end else begin
        if (i == 3) rstn = 1'b1;
        @(posedge clk); #1;
        drive(req_t[i], tail_t[i], gnt_t[i], exp_t[i], "reset_mid");
        @(negedge clk);
      end
      obs = {bus.sel, bus.port_req, bus.vc_deq, bus.lock_active};
      e = exp_q.pop_front(); nm = name_q.pop_front(); checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL %s[%0d]: got %b want %b (sel_req_deq_lock)", nm, i, obs, e);
      end
    end
  endtask
`else
  task automatic test_flit_rr();
    logic [V-1:0] req_t [4] = '{4'b0110, 4'b0110, 4'b0110, 4'b0100};
    out_t exp_t [4] = '{10'b0010_1_0010_0, 10'b0100_1_0100_0, 10'b0010_1_0010_0, 10'b0100_1_0100_0};
    out_t obs, e;
    string nm;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      drive(req_t[i], 4'b0000, 1'b1, exp_t[i], "flit_rr");
      @(negedge clk);
      obs = {bus.sel, bus.port_req, bus.vc_deq, bus.lock_active};
      e = exp_q.pop_front(); nm = name_q.pop_front(); checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL %s[%0d]: got %b want %b (sel_req_deq_lock)", nm, i, obs, e);
      end
    end
  endtask
`endif

  task automatic test_back_to_back();
    logic [V-1:0] req, tail, esel, edeq;
    logic         gnt, epreq;
    int           m_ptr, m_lvc, widx, cand;
    bit           m_locked;
    out_t obs, e;
    string nm;
    m_ptr = 0; m_lvc = 0; m_locked = 1'b0;
    do_reset();
    for (int i = 0; i < 300; i++) begin
      req  = V'($urandom_range(0, 15));
      tail = V'($urandom_range(0, 15));
      gnt  = ($urandom_range(0, 3) != 0);
      esel = '0; epreq = 1'b0; widx = 0;
      if (m_locked) begin
        esel  = 4'b0001 << m_lvc;
        epreq = req[VW'(m_lvc)];
        widx  = m_lvc;
      end else begin
        for (int k = 0; k < V; k++) begin
          cand = (m_ptr + k) % V;
          if (!epreq && req[VW'(cand)]) begin
            widx  = cand;
            esel  = 4'b0001 << cand;
            epreq = 1'b1;
          end
        end
      end
      edeq = (gnt && epreq) ? esel : 4'b0000;
      @(posedge clk); #1;
      drive(req, tail, gnt, {esel, epreq, edeq, m_locked}, "back_to_back");
      @(negedge clk);
      obs = {bus.sel, bus.port_req, bus.vc_deq, bus.lock_active};
      e = exp_q.pop_front(); nm = name_q.pop_front(); checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL %s[%0d]: got %b want %b (req=%b tail=%b gnt=%b)", nm, i, obs, e, req, tail, gnt);
      end
      if (gnt && epreq) begin
`ifdef XB_PKT_LOCK_EN
        if (!m_locked && !tail[VW'(widx)]) begin
          m_locked = 1'b1;
          m_lvc    = widx;
        end else if (m_locked && tail[VW'(m_lvc)]) begin
          m_locked = 1'b0;
        end
`endif
        m_ptr = (widx + 1) % V;
      end
    end
  endtask

  initial begin
    bus.vc_req   = '0;
    bus.vc_tail  = '0;
    bus.port_gnt = 1'b0;
    test_reset();
    test_round_robin();
    test_wrap();
    test_ignored_gnt();
`ifdef XB_PKT_LOCK_EN
    test_lock();
    test_bubble();
    test_reset_mid();
`else
    test_flit_rr();
`endif
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
